// File: rtl/spi_accel_pkg.sv
// Shared types and constants for the SPI accelerometer responder.
// No logic; pure declarations plus a read-only address decode helper.
// Not applicable (no flow control in a package).
package spi_accel_pkg;

  typedef enum logic [1:0] {IDLE, CMD, READ, WRITE} state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } sample_t;

  localparam logic [5:0] ADDR_DEVID  = 6'h00;
  localparam logic [5:0] ADDR_DATAX0 = 6'h32;
  localparam logic [5:0] ADDR_DATAX1 = 6'h33;
  localparam logic [5:0] ADDR_DATAY0 = 6'h34;
  localparam logic [5:0] ADDR_DATAY1 = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0 = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1 = 6'h37;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_MB_BIT = 6;

  // DEVID and the sample window are owned by the slave, not the master.
  function automatic logic is_read_only(input logic [5:0] a);
    return (a == ADDR_DEVID) || ((a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1));
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one SPI pin, with optional rise/fall strobes.
// Latency: STAGES clk cycles to o_sync, one more flop for edge detect.
// No backpressure; edges are single-cycle strobes.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGES   = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= {STAGES{RST_VAL}};
    else          r_sync <= {r_sync[STAGES-2:0], i_pin};
  end

  assign o_sync = r_sync[STAGES-1];

  generate
    if (EDGES) begin : g_edges
      logic r_prev;
      // Remember the previous synced level for edge detection.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev <= RST_VAL;
        else          r_prev <= r_sync[STAGES-1];
      end
      assign o_rise = r_sync[STAGES-1] & ~r_prev;
      assign o_fall = ~r_sync[STAGES-1] & r_prev;
    end else begin : g_no_edges
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_accel_slave.sv
// SPI mode-3 responder with ADXL345-style 64-byte map and atomic sample window.
// Latency: SYNC_STAGES+1 clk from each SPI edge; reg_wr one cycle after the write.
// No backpressure; master must respect minimum spi_clk phase widths.
module spi_accel_slave
  import spi_accel_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_spi_clk,
  input  logic        i_cs,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic        o_miso_oe,
  input  logic        i_sample_valid,
  input  logic [15:0] i_sample_x,
  input  logic [15:0] i_sample_y,
  input  logic [15:0] i_sample_z,
  output logic        o_reg_wr,
  output logic [5:0]  o_reg_wr_addr,
  output logic [7:0]  o_reg_wr_data,
  output logic        o_busy
);

  logic w_sclk_unused_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_unused_rise, w_mosi_unused_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGES(1'b1)) u_sync_sclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_spi_clk),
    .o_sync(w_sclk_unused_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGES(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_cs),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_mosi),
    .o_sync(w_mosi), .o_rise(w_mosi_unused_rise), .o_fall(w_mosi_unused_fall));

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;
  logic [5:0] r_addr;
  logic       r_mb;
  logic       r_first;
  logic       r_miso, r_miso_oe;
  logic       r_wr_pend, r_reg_wr;
  logic [5:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_pend_vld;
  sample_t    r_pend;
  logic [7:0] r_regs [64];

  logic [7:0] w_rx_next;
  logic [5:0] w_addr_step;
  sample_t    w_sample;

  assign w_rx_next   = {r_rx, w_mosi};
  assign w_addr_step = r_mb ? (r_addr + 6'd1) : r_addr;
  assign w_sample    = '{x: i_sample_x, y: i_sample_y, z: i_sample_z};

  // Transaction FSM, shift registers, register file and sample buffering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx       <= 7'd0;
      r_tx       <= 8'd0;
      r_addr     <= 6'd0;
      r_mb       <= 1'b0;
      r_first    <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_reg_wr   <= 1'b0;
      r_wr_addr  <= 6'd0;
      r_wr_data  <= 8'd0;
      r_pend_vld <= 1'b0;
      r_pend     <= '0;
      for (int i = 0; i < 64; i++) r_regs[i] <= (i == 0) ? DEVID : 8'h00;
    end else begin
      r_wr_pend <= 1'b0;
      r_reg_wr  <= r_wr_pend;
      if (w_cs_rise) begin
        r_state   <= IDLE;
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
        // A sample that arrived mid-burst becomes visible only now.
        if (r_pend_vld) begin
          r_regs[ADDR_DATAX0] <= r_pend.x[7:0];
          r_regs[ADDR_DATAX1] <= r_pend.x[15:8];
          r_regs[ADDR_DATAY0] <= r_pend.y[7:0];
          r_regs[ADDR_DATAY1] <= r_pend.y[15:8];
          r_regs[ADDR_DATAZ0] <= r_pend.z[7:0];
          r_regs[ADDR_DATAZ1] <= r_pend.z[15:8];
          r_pend_vld          <= 1'b0;
        end
      end else if (w_cs_fall) begin
        r_state   <= CMD;
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end else if (!w_cs_sync) begin
        case (r_state)
          CMD: begin
            if (w_sclk_rise) begin
              r_rx      <= w_rx_next[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_addr  <= w_rx_next[5:0];
                r_mb    <= w_rx_next[CMD_MB_BIT];
                r_first <= 1'b1;
                if (w_rx_next[CMD_RW_BIT]) begin
                  r_state   <= READ;
                  r_tx      <= r_regs[w_rx_next[5:0]];
                  r_miso_oe <= 1'b1;
                end else begin
                  r_state <= WRITE;
                end
              end
            end
          end
          READ: begin
            if (w_sclk_fall) begin
              r_miso <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
            end else if (w_sclk_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_addr <= w_addr_step;
                r_tx   <= r_regs[w_addr_step];
              end
            end
          end
          WRITE: begin
            if (w_sclk_rise) begin
              r_rx      <= w_rx_next[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                // Without auto-increment only the first data byte lands.
                if ((r_first || r_mb) && !is_read_only(r_addr)) begin
                  r_regs[r_addr] <= w_rx_next;
                  r_wr_pend      <= 1'b1;
                  r_wr_addr      <= r_addr;
                  r_wr_data      <= w_rx_next;
                end
                r_first <= 1'b0;
                if (r_mb) r_addr <= r_addr + 6'd1;
              end
            end
          end
          default: ;
        endcase
      end
      // Placed last so a strobe coinciding with CS rise overrides the pending copy.
      if (i_sample_valid) begin
        if (w_cs_sync) begin
          r_regs[ADDR_DATAX0] <= w_sample.x[7:0];
          r_regs[ADDR_DATAX1] <= w_sample.x[15:8];
          r_regs[ADDR_DATAY0] <= w_sample.y[7:0];
          r_regs[ADDR_DATAY1] <= w_sample.y[15:8];
          r_regs[ADDR_DATAZ0] <= w_sample.z[7:0];
          r_regs[ADDR_DATAZ1] <= w_sample.z[15:8];
        end else begin
          r_pend     <= w_sample;
          r_pend_vld <= 1'b1;
        end
      end
    end
  end

  assign o_miso        = r_miso;
  assign o_miso_oe     = r_miso_oe;
  assign o_reg_wr      = r_reg_wr;
  assign o_reg_wr_addr = r_reg_wr ? r_wr_addr : 6'd0;
  assign o_reg_wr_data = r_reg_wr ? r_wr_data : 8'd0;
  assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_spi_accel_slave.sv
// Directed bench for spi_accel_slave with a scoreboard for MISO bytes and reg_wr pulses.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_spi_accel_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, cs, mosi;
  logic        miso, miso_oe;
  logic        sample_valid;
  logic [15:0] sx, sy, sz;
  logic        reg_wr;
  logic [5:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  exp_rd_q[$];
  logic [7:0]  got_rd_q[$];
  logic [13:0] exp_wr_q[$];

  logic [7:0] rx_b;
  bit         oe_any, oe_all;

  spi_accel_slave dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_spi_clk(sclk), .i_cs(cs), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe), .i_sample_valid(sample_valid),
    .i_sample_x(sx), .i_sample_y(sy), .i_sample_z(sz),
    .o_reg_wr(reg_wr), .o_reg_wr_addr(reg_wr_addr), .o_reg_wr_data(reg_wr_data),
    .o_busy(busy));

  initial forever #5 clk = ~clk;

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master drives MOSI on the falling edge and samples MISO just before the rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int n, input bit cap);
    rx_b = 8'h00; oe_any = 1'b0; oe_all = 1'b1;
    for (int b = 0; b < n; b++) begin
      sclk = 1'b0; mosi = tx[7-b];
      wait_clk(HALF);
      rx_b = {rx_b[6:0], miso};
      oe_any = oe_any | miso_oe;
      oe_all = oe_all & miso_oe;
      sclk = 1'b1;
      wait_clk(HALF);
    end
    if (cap) got_rd_q.push_back(rx_b);
  endtask

  task automatic cs_low();
    cs = 1'b0; wait_clk(HALF);
  endtask

  task automatic cs_high();
    cs = 1'b1; wait_clk(2*HALF);
  endtask

  task automatic spi_read(input logic [7:0] cmd, input int n);
    cs_low();
    spi_bits(cmd, 8, 1'b0);
    chk("oe_low_in_cmd", 16'(oe_any), 16'd0);
    for (int k = 0; k < n; k++) begin
      spi_bits(8'h00, 8, 1'b1);
      chk("oe_high_in_data", 16'(oe_all), 16'd1);
    end
    cs_high();
    chk("oe_after_cs", 16'(miso_oe), 16'd0);
  endtask

  task automatic spi_write(input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1, input int n);
    cs_low();
    spi_bits(cmd, 8, 1'b0);
    spi_bits(d0, 8, 1'b0);
    if (n > 1) spi_bits(d1, 8, 1'b0);
    cs_high();
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sx = x; sy = y; sz = z; sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT (or the master model) presents a result.
  always @(negedge clk) begin
    if (reg_wr) begin
      if (exp_wr_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_reg_wr: got addr %0h data %0h expected none", reg_wr_addr, reg_wr_data);
      end else begin
        chk("reg_wr", 16'({reg_wr_addr, reg_wr_data}), 16'(exp_wr_q.pop_front()));
      end
    end
    if (got_rd_q.size() > 0) begin
      if (exp_rd_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_miso_byte: got %0h expected none", got_rd_q.pop_front());
      end else begin
        chk("miso_byte", 16'(got_rd_q.pop_front()), 16'(exp_rd_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; sclk = 1'b1; cs = 1'b1; mosi = 1'b0;
    sample_valid = 1'b0; sx = 16'h0; sy = 16'h0; sz = 16'h0;
    wait_clk(5);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_miso", 16'(miso), 16'd0);
    chk("rst_miso_oe", 16'(miso_oe), 16'd0);
    chk("rst_reg_wr", 16'(reg_wr), 16'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // DEVID read
    exp_rd_q.push_back(8'hE5);
    spi_read(8'h80, 1);

    // Single write then read back
    exp_wr_q.push_back({6'h2D, 8'h08});
    spi_write(8'h2D, 8'h08, 8'h00, 1);
    exp_rd_q.push_back(8'h08);
    spi_read(8'hAD, 1);

    // Sample while idle, burst read of the window
    pulse_sample(16'h0123, 16'hFFFE, 16'h8000);
    wait_clk(2);
    foreach (exp_rd_q[i]) ;
    exp_rd_q.push_back(8'h23); exp_rd_q.push_back(8'h01);
    exp_rd_q.push_back(8'hFE); exp_rd_q.push_back(8'hFF);
    exp_rd_q.push_back(8'h00); exp_rd_q.push_back(8'h80);
    spi_read(8'hF2, 6);

    // Sample mid-burst is deferred to CS rise
    exp_rd_q.push_back(8'h23); exp_rd_q.push_back(8'h01);
    cs_low();
    spi_bits(8'hF2, 8, 1'b0);
    pulse_sample(16'h1111, 16'hFFFE, 16'h8000);
    spi_bits(8'h00, 8, 1'b1);
    spi_bits(8'h00, 8, 1'b1);
    cs_high();
    exp_rd_q.push_back(8'h11); exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'hFE); exp_rd_q.push_back(8'hFF);
    spi_read(8'hF2, 4);

    // Aborted partial data byte
    cs_low();
    spi_bits(8'h2D, 8, 1'b0);
    spi_bits(8'hFF, 4, 1'b0);
    cs = 1'b1;
    wait_clk(HALF);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_miso_oe", 16'(miso_oe), 16'd0);
    wait_clk(HALF);
    exp_rd_q.push_back(8'h08);
    spi_read(8'hAD, 1);

    // Auto-increment write wrapping into read-only DEVID
    exp_wr_q.push_back({6'h3F, 8'hAA});
    spi_write(8'h7F, 8'hAA, 8'hBB, 2);
    exp_rd_q.push_back(8'hAA);
    spi_read(8'hBF, 1);
    exp_rd_q.push_back(8'hE5);
    spi_read(8'h80, 1);

    // Asynchronous reset in the middle of a read
    cs_low();
    spi_bits(8'h80, 8, 1'b0);
    spi_bits(8'h00, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_miso", 16'(miso), 16'd0);
    chk("midrst_miso_oe", 16'(miso_oe), 16'd0);
    chk("midrst_reg_wr", 16'(reg_wr), 16'd0);
    cs = 1'b1; sclk = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    exp_rd_q.push_back(8'h00);
    spi_read(8'hAD, 1);
    exp_rd_q.push_back(8'h00);
    spi_read(8'hB2, 1);
    exp_rd_q.push_back(8'hE5);
    spi_read(8'h80, 1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 200 && got_rd_q.size() > 0; i++) wait_clk(1);
    while (exp_rd_q.size() > 0) begin
      n_total++;
      $display("FAIL missing_miso_byte: got none expected %0h", exp_rd_q.pop_front());
    end
    while (exp_wr_q.size() > 0) begin
      n_total++;
      $display("FAIL missing_reg_wr: got none expected %0h", exp_wr_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
